// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and response codes used by
// both the completer and the initiator.
package apb_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic OKAY   = 1'b0;
   localparam logic SLVERR = 1'b1;

   localparam int unsigned CNT_W = 4;

endpackage : apb_pkg

// File: rtl/apb_regfile.sv
// DEPTH x WDATA register bank: one synchronous write port, one
// asynchronous read port, synchronous active-low clear.
module apb_regfile #(
   parameter int unsigned WDATA = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WDATA-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WDATA-1:0]         rdata_o
);

   logic [WDATA-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : apb_regfile

// File: rtl/apb_slave.sv
// APB completer: latches the setup phase, inserts WAIT_CYCLES wait states,
// then answers from the register bank with range-checked error response.
module apb_slave
   import apb_pkg::*;
#(
   parameter int unsigned WDATA       = 16,
   parameter int unsigned WADDR       = 16,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic             i_PCLK,
   input  logic             i_PRESETn,
   input  logic             i_PSELx,
   input  logic             i_PENABLE,
   input  logic             i_PWRITE,
   input  logic [WADDR-1:0] i_PADDR,
   input  logic [WDATA-1:0] i_PWDATA,
   output logic             o_PREADY,
   output logic [WDATA-1:0] o_PRDATA,
   output logic             o_PSLVERR
);

   localparam int unsigned IDXW   = $clog2(DEPTH);
   localparam int unsigned AEXT_W = WADDR + 1;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WADDR-1:0] addr_q;
   logic             wr_q;
   logic [WDATA-1:0] wdata_q;
   logic [WDATA-1:0] prdata_q, prdata_d;
   logic             pslverr_q, pslverr_d;

   logic             latch_c;
   logic [WADDR-1:0] addr_nxt_c;
   logic             wr_nxt_c;
   logic [WDATA-1:0] wdata_nxt_c;
   logic             err_c;
   logic             we_c;
   logic [WDATA-1:0] rdata_c;

   // Setup phase is only accepted from IDLE; later bus changes are ignored.
   assign latch_c     = (state_q == IDLE) && i_PSELx && !i_PENABLE;
   assign addr_nxt_c  = latch_c ? i_PADDR  : addr_q;
   assign wr_nxt_c    = latch_c ? i_PWRITE : wr_q;
   assign wdata_nxt_c = latch_c ? i_PWDATA : wdata_q;

   // Range check on the full address so out-of-range indices never alias.
   assign err_c = ({1'b0, addr_nxt_c} >= AEXT_W'(DEPTH));

   always_ff @(posedge i_PCLK) begin
      if (!i_PRESETn) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         prdata_q  <= '0;
         pslverr_q <= OKAY;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_nxt_c;
         wr_q      <= wr_nxt_c;
         wdata_q   <= wdata_nxt_c;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      we_c      = 1'b0;

      case (state_q)
         IDLE: begin
            if (latch_c) begin
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (!i_PSELx) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!i_PSELx) begin
               state_d   = IDLE;
               prdata_d  = '0;
               pslverr_d = OKAY;
            end else if (i_PENABLE) begin
               we_c      = wr_q && (pslverr_q == OKAY);
               state_d   = IDLE;
               prdata_d  = '0;
               pslverr_d = OKAY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Response is captured on entry to DONE from the latched transfer.
      if ((state_d == DONE) && (state_q != DONE)) begin
         pslverr_d = err_c ? SLVERR : OKAY;
         prdata_d  = (!wr_nxt_c && !err_c) ? rdata_c : '0;
      end
   end

   assign o_PREADY  = (state_q == DONE);
   assign o_PRDATA  = prdata_q;
   assign o_PSLVERR = pslverr_q;

   apb_regfile #(
      .WDATA (WDATA),
      .DEPTH (DEPTH)
   ) u_regfile (
      .clk_i   (i_PCLK),
      .rst_ni  (i_PRESETn),
      .we_i    (we_c),
      .waddr_i (addr_q[IDXW-1:0]),
      .wdata_i (wdata_q),
      .raddr_i (addr_nxt_c[IDXW-1:0]),
      .rdata_o (rdata_c)
   );

endmodule : apb_slave

// File: doc/apb_slave.md
# apb_slave

APB completer (slave) for the `apb_master` initiator. It decodes `WADDR`-bit transfers into a `DEPTH`-entry register bank of `WDATA`-bit registers. It inserts a fixed, parameterised number of wait states, returns read data, and flags out-of-range addresses on `o_PSLVERR`. It is the far end of the bus that `apb_master` drives, and the two are paired in system benches.

## Interface
Parameters:
- `WDATA`, 16: data width of the bus and of each register.
- `WADDR`, 16: address width.
- `DEPTH`, 16: number of registers. Must be a power of 2, ≤ 2^WADDR.
- `WAIT_CYCLES`, 0: wait states inserted per transfer. Range 0..15.

Ports (name, direction, width, meaning):
- `i_PCLK`  in  1  single clock; all logic on the rising edge.
- `i_PRESETn`  in  1  reset, synchronous, active-low.
- `i_PSELx`  in  1  slave select from the master.
- `i_PENABLE`  in  1  access-phase indicator.
- `i_PWRITE`  in  1  1 = write, 0 = read.
- `i_PADDR`  in  WADDR  register index. Valid range 0..DEPTH-1.
- `i_PWDATA`  in  WDATA  write data.
- `o_PREADY`  out  1  transfer completes this cycle.
- `o_PRDATA`  out  WDATA  read data. Valid only while `o_PREADY`=1 on a read.
- `o_PSLVERR`  out  1  error response. Valid only while `o_PREADY`=1.

## Operation
- Reset (`i_PRESETn`=0 at a clock edge):
  - state returns to IDLE; wait counter = 0;
  - `o_PREADY`=0, `o_PRDATA`=0, `o_PSLVERR`=0;
  - all registers = 0.
  - Reset mid-transfer abandons the transfer; no write is committed.
- FSM states are IDLE, WAIT and DONE. `o_PREADY` is high exactly when the state is DONE, and is decoded from a register.
- IDLE:
  - On `i_PSELx`=1 and `i_PENABLE`=0 (setup phase), latch `i_PADDR`, `i_PWRITE` and `i_PWDATA`, and load counter = `WAIT_CYCLES`.
  - Go to DONE if `WAIT_CYCLES`=0, else to WAIT.
  - `i_PSELx`=1 with `i_PENABLE`=1 in IDLE is a protocol violation: ignore it and stay in IDLE.
- WAIT:
  - If `i_PSELx`=0, abort to IDLE.
  - Otherwise decrement the counter; when the counter==1, go to DONE.
- On entering DONE:
  - error = (latched addr ≥ `DEPTH`), loaded into `o_PSLVERR`;
  - `o_PRDATA` = bank[latched addr] when it is a read without error, else 0.
- DONE:
  - On `i_PSELx`=1 and `i_PENABLE`=1, the transfer completes at this edge. If it is a write without error, bank[latched addr] ← latched data. Go to IDLE.
  - `o_PRDATA` and `o_PSLVERR` clear to 0 on leaving DONE.
  - If `i_PSELx`=0, abort to IDLE with no commit.
- Out-of-range write: no register changes; `o_PSLVERR`=1.
- Out-of-range read: `o_PRDATA`=0; `o_PSLVERR`=1.
- Index decode: register index = latched `i_PADDR[$clog2(DEPTH)-1:0]`. The range check uses the full `WADDR` bits, so addresses do not alias.
- The block uses latched address, direction and data only. Changes on the bus after the setup phase have no effect.

## Timing
- For a setup phase sampled at edge N:
  - `o_PREADY` rises after edge N + `WAIT_CYCLES`;
  - the transfer completes at edge N+1+`WAIT_CYCLES`;
  - total transfer = 2+`WAIT_CYCLES` cycles, which matches the APB minimum of 2.
- A write is visible to a read whose setup phase is sampled at the completion edge or later.
- Back-to-back transfers: the next setup is accepted in IDLE the cycle after completion, with no dead cycle beyond APB's own.
- `o_PREADY` is never high for two consecutive completion edges.
- The wait counter width is 4 bits.

## Structure
- Shared package `apb_pkg` holds:
  - state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - response constants: OKAY=1'b0, SLVERR=1'b1.
  - `apb_master` uses the same package.
- Sub-module `apb_regfile`: `DEPTH`×`WDATA`, one synchronous write port, one asynchronous read port, synchronous reset to 0. The FSM, latches and counter live in `apb_slave`.

## Test plan
- Zero-wait write/read (`WAIT_CYCLES`=0): write 0x1312 to addr 0x0002, then read addr 0x0002.
  - `o_PREADY` is high in each access cycle;
  - `o_PRDATA`=0x1312; `o_PSLVERR`=0;
  - each transfer takes 2 cycles.
- Wait states (`WAIT_CYCLES`=3): write 0x654E to addr 0x0005.
  - `o_PREADY` is low for exactly 3 access cycles, then high for 1.
  - A readback returns 0x654E after another 3 waits.
- Out-of-range: write 0xBEEF to addr 0xA1A2.
  - `o_PSLVERR`=1 with `o_PREADY`; all 16 registers are unchanged.
  - A read of 0x10A5 returns `o_PRDATA`=0 with `o_PSLVERR`=1.
- Abort (`WAIT_CYCLES`=3): drop `i_PSELx` during WAIT on a write of 0xAAAA to addr 1.
  - FSM returns to IDLE; `o_PREADY` never rises; reg1 keeps its prior value.
- Reset mid-transfer: assert `i_PRESETn`=0 in DONE of a write of 0x5555 to addr 3.
  - Next cycle all outputs are 0 and reg3 = 0.
  - A following read of addr 3 returns 0.
- Back-to-back: alternate write 0x0001..0x000F to addrs 0..14 with immediate readbacks, no idle cycles.
  - Every readback matches;
  - `o_PREADY` pulses are exactly 1 cycle each.
